// File: rtl/memory_ctrl_pkg.sv
// Shared constants and types for the two-requester memory arbiter.
// State encoding is fixed so waveforms decode the same across tools.
package memory_ctrl_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 2;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } op_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: pointer picks who wins a tie,
// a lone requester always wins.
module rr_arbiter2
  import memory_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               pointer,
  output logic [NUM_REQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (pointer) begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end else begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates two requesters onto one 4x8 memory port using a
// four-state SETUP/STROBE/HOLD access cycle.
module memory_arbiter
  import memory_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_store,
  input  logic [DATA_W-1:0] mem_q
);

  state_t             r_state;
  state_t             w_state_nxt;
  op_t                r_op;
  op_t                w_sel_op;
  logic               r_ptr;
  logic               r_id;
  logic [DATA_W-1:0]  r_rdata;
  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_gnt;
  logic [NUM_REQ-1:0] w_ack;
  logic               w_store;
  logic               w_grant;

  assign w_req = {req1, req0};

  rr_arbiter2 u_rr (
    .req     (w_req),
    .pointer (r_ptr),
    .gnt     (w_gnt)
  );

  assign w_grant  = (r_state == IDLE) && (|w_gnt);
  assign w_sel_op = w_gnt[1] ? '{we1, addr1, wdata1}
                             : '{we0, addr0, wdata0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_store     = 1'b0;
    w_ack       = '0;
    unique case (r_state)
      IDLE: begin
        if (|w_gnt) w_state_nxt = SETUP;
      end
      SETUP: begin
        w_state_nxt = STROBE;
      end
      STROBE: begin
        w_state_nxt = HOLD;
        w_store     = r_op.we;
      end
      HOLD: begin
        w_state_nxt = IDLE;
        w_ack       = r_id ? 2'b10 : 2'b01;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Op is captured only at grant; requester inputs are ignored after
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_id    <= 1'b0;
      r_ptr   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_op <= w_sel_op;
        r_id <= w_gnt[1];
      end
      if (r_state == STROBE && !r_op.we) r_rdata <= mem_q;
      if (r_state == HOLD) r_ptr <= ~r_id;
    end
  end

  assign ack0      = w_ack[0];
  assign ack1      = w_ack[1];
  assign rdata     = r_rdata;
  assign busy      = (r_state != IDLE);
  assign mem_data  = r_op.data;
  assign mem_addr  = r_op.addr;
  assign mem_store = w_store;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural 4x8 memory.
// Vectors are single transactions; sequences cover reset and round-robin.
module tb_memory_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1, we0, we1;
  logic [1:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, busy, mem_store;
  logic [7:0] rdata, mem_data, mem_q;
  logic [1:0] mem_addr;
  logic [7:0] mem [4];

  int checks   = 0;
  int failures = 0;

  memory_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .busy      (busy),
    .mem_data  (mem_data),
    .mem_addr  (mem_addr),
    .mem_store (mem_store),
    .mem_q     (mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_store) mem[mem_addr] <= mem_data;
  assign mem_q = mem[mem_addr];

  typedef struct {
    logic       r0, r1, w0, w1;
    logic [1:0] a0, a1;
    logic [7:0] d0, d1;
    logic       gid;
    logic [1:0] ea;
    logic [7:0] ed;
    logic       es;
    logic [7:0] er;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic run_op(input vec_t v);
    @(negedge clk);
    req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    @(posedge clk); @(negedge clk);
    req0 = 0; req1 = 0; we0 = ~v.w0; we1 = ~v.w1;
    addr0 = ~v.a0; addr1 = ~v.a1; wdata0 = ~v.d0; wdata1 = ~v.d1;
    chk("setup_busy", busy, 1);
    chk("setup_ack", {ack1, ack0}, 0);
    chk("setup_store", mem_store, 0);
    chk("setup_addr", mem_addr, v.ea);
    chk("setup_data", mem_data, v.ed);
    @(posedge clk); @(negedge clk);
    chk("strobe_store", mem_store, v.es);
    chk("strobe_ack", {ack1, ack0}, 0);
    chk("strobe_addr", mem_addr, v.ea);
    chk("strobe_data", mem_data, v.ed);
    @(posedge clk); @(negedge clk);
    chk("hold_ack", {ack1, ack0}, v.gid ? 2'b10 : 2'b01);
    chk("hold_store", mem_store, 0);
    chk("hold_busy", busy, 1);
    chk("hold_rdata", rdata, v.er);
    chk("hold_addr", mem_addr, v.ea);
    chk("hold_data", mem_data, v.ed);
    @(posedge clk); @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_ack", {ack1, ack0}, 0);
    chk("idle_addr", mem_addr, v.ea);
    chk("idle_data", mem_data, v.ed);
    chk("idle_rdata", rdata, v.er);
  endtask

  initial begin
    int n_ack;
    vec_t fin;
    //         r0 r1 w0 w1 a0 a1 d0     d1    gid ea ed    es er
    vecs[0] = '{1, 0, 1, 0, 2, 0, 8'hA5, 8'h00, 0, 2, 8'hA5, 1, 8'h00};
    vecs[1] = '{0, 1, 0, 0, 0, 2, 8'h00, 8'h00, 1, 2, 8'h00, 0, 8'hA5};
    vecs[2] = '{0, 1, 0, 1, 0, 3, 8'h00, 8'h5A, 1, 3, 8'h5A, 1, 8'hA5};
    vecs[3] = '{1, 1, 1, 0, 0, 3, 8'h77, 8'h99, 0, 0, 8'h77, 1, 8'hA5};
    vecs[4] = '{1, 1, 0, 0, 0, 3, 8'h00, 8'h00, 1, 3, 8'h00, 0, 8'h5A};
    vecs[5] = '{1, 0, 1, 0, 1, 0, 8'h3C, 8'h00, 0, 1, 8'h3C, 1, 8'h5A};
    vecs[6] = '{1, 0, 0, 0, 1, 0, 8'hFF, 8'h00, 0, 1, 8'hFF, 0, 8'h3C};
    vecs[7] = '{1, 1, 0, 0, 0, 2, 8'h00, 8'h00, 1, 2, 8'h00, 0, 8'hA5};
    vecs[8] = '{1, 1, 0, 1, 0, 1, 8'h00, 8'h44, 0, 0, 8'h00, 0, 8'h77};
    vecs[9] = '{1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h22};

    rst_n = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_store", mem_store, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    rst_n = 1;

    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // Reset asserted mid-STROBE truncates the write with no ack
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 3; wdata0 = 8'hEE;
    @(posedge clk); @(negedge clk);
    req0 = 0;
    @(posedge clk); @(negedge clk);
    chk("pre_rst_store", mem_store, 1);
    #2 rst_n = 0;
    #1;
    chk("async_store", mem_store, 0);
    chk("async_busy", busy, 0);
    chk("async_ack", {ack1, ack0}, 0);
    chk("async_rdata", rdata, 0);
    chk("async_addr", mem_addr, 0);
    chk("async_data", mem_data, 0);
    @(posedge clk); @(negedge clk);
    chk("rst_hold_ack", {ack1, ack0}, 0);
    chk("rst_hold_busy", busy, 0);
    rst_n = 1;

    // Both requesters held: grants must alternate starting at 0
    req0 = 1; we0 = 1; addr0 = 0; wdata0 = 8'h11;
    req1 = 1; we1 = 1; addr1 = 0; wdata1 = 8'h22;
    n_ack = 0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); @(negedge clk);
      chk("one_ack", ack0 & ack1, 0);
      if (ack0 | ack1) begin
        chk("rr_id", ack1, n_ack % 2);
        chk("rr_cycle", i, 3 + 4 * n_ack);
        n_ack++;
      end
    end
    req0 = 0; req1 = 0;
    chk("rr_count", n_ack, 4);
    chk("rr_rdata", rdata, 0);

    fin = vecs[9];
    run_op(fin);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
